sdram_av_responder: RTL and testbench

SDRAM_AV_RESPONDER -- requirements
Module: sdram_av_responder

---
 rtl/sdram_av_responder_if.sv | 34 +++
 rtl/sdram_av_responder.sv | 151 +++++++++++++++
 tb/tb_sdram_av_responder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_av_responder_if.sv
// Avalon-style bus between a host and the SDRAM responder model.
// Fields:
//   sdram_av_address       word address (only the low ADDR_BITS are decoded)
//   sdram_av_byteenable_n  active-low byte enables, bit 0 -> [7:0], bit 1 -> [15:8]
//   sdram_av_chipselect    qualifies read_n / write_n
//   sdram_av_writedata     write data
//   sdram_av_read_n        active-low read request
//   sdram_av_write_n       active-low write request
//   sdram_av_readdata      read data, held between valid pulses
//   sdram_av_readdatavalid one-cycle qualifier for readdata
//   sdram_av_waitrequest   stall; no command is taken while high
interface sdram_av_responder_if;
  logic [21:0] sdram_av_address;
  logic [1:0]  sdram_av_byteenable_n;
  logic        sdram_av_chipselect;
  logic [15:0] sdram_av_writedata;
  logic        sdram_av_read_n;
  logic        sdram_av_write_n;
  logic [15:0] sdram_av_readdata;
  logic        sdram_av_readdatavalid;
  logic        sdram_av_waitrequest;

  modport master (
    output sdram_av_address, sdram_av_byteenable_n, sdram_av_chipselect,
           sdram_av_writedata, sdram_av_read_n, sdram_av_write_n,
    input  sdram_av_readdata, sdram_av_readdatavalid, sdram_av_waitrequest
  );

  modport slave (
    input  sdram_av_address, sdram_av_byteenable_n, sdram_av_chipselect,
           sdram_av_writedata, sdram_av_read_n, sdram_av_write_n,
    output sdram_av_readdata, sdram_av_readdatavalid, sdram_av_waitrequest
  );
endinterface

// File: rtl/sdram_av_responder.sv
// SDRAM-like Avalon responder: 16-bit backing RAM with fixed read latency,
// a bounded number of reads in flight, and periodic refresh windows that
// stall new commands.
// Ports:
//   clk            single rising-edge clock
//   reset_n        synchronous active-low reset (RAM contents are kept)
//   av             slave side of sdram_av_responder_if
//   protocol_error sticky flag: read_n and write_n both low with chipselect
//
// state | meaning
// ------+------------------------------------------------------
// IDLE  | no reads in flight (pending == 0)
// BUSY  | at least one read in flight; only state where data returns
module sdram_av_responder #(
  parameter int ADDR_BITS      = 10,
  parameter int READ_LATENCY   = 3,
  parameter int MAX_PENDING    = 4,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sdram_av_responder_if.slave  av,
  output logic                 protocol_error
);

  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int RCW    = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int PW     = $clog2(MAX_PENDING + 1);
  // The output register is the last latency stage, so the internal shift
  // chain is one shorter than READ_LATENCY.
  localparam int STAGES = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [15:0]          ram [DEPTH];
  logic [ADDR_BITS-1:0] word_addr;
  logic [RCW-1:0]       ref_cnt;
  logic                 refresh_active;
  logic                 wait_req;
  logic [PW-1:0]        pending;
  logic [PW-1:0]        pending_nxt;
  logic                 rd_acc;
  logic                 wr_acc;
  logic                 cmd_clash;
  logic [STAGES-1:0]    vld_pipe;
  logic [15:0]          dat_pipe [STAGES];
  logic                 tail_vld;
  logic [15:0]          tail_dat;
  logic                 rdv_q;
  logic [15:0]          rdata_q;

  assign word_addr      = av.sdram_av_address[ADDR_BITS-1:0];
  assign refresh_active = (ref_cnt >= RCW'(REFRESH_PERIOD - REFRESH_CYCLES));
  // Built from registers only so the host never sees a combinational path
  // from its own request back to the stall.
  assign wait_req       = refresh_active | (pending == PW'(MAX_PENDING));

  assign cmd_clash = av.sdram_av_chipselect & ~av.sdram_av_read_n & ~av.sdram_av_write_n;
  assign rd_acc    = av.sdram_av_chipselect & ~av.sdram_av_read_n & av.sdram_av_write_n & ~wait_req;
  assign wr_acc    = av.sdram_av_chipselect & ~av.sdram_av_write_n & av.sdram_av_read_n & ~wait_req;

  assign av.sdram_av_waitrequest   = wait_req;
  assign av.sdram_av_readdatavalid = rdv_q;
  assign av.sdram_av_readdata      = rdata_q;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign tail_vld = rd_acc;
      assign tail_dat = ram[word_addr];
    end else begin : g_latn
      assign tail_vld = vld_pipe[STAGES-1];
      assign tail_dat = dat_pipe[STAGES-1];
    end
  endgenerate

  always_comb begin
    pending_nxt = pending;
    if (rd_acc && !rdv_q)
      pending_nxt = pending + 1'b1;
    else if (!rd_acc && rdv_q)
      pending_nxt = pending - 1'b1;
  end

  // Read data is captured in the accept cycle, so a read observes every
  // write accepted before it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      for (int i = 1; i < STAGES; i++)
        vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dat_pipe[0] <= ram[word_addr];
    for (int i = 1; i < STAGES; i++)
      dat_pipe[i] <= dat_pipe[i-1];
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      if (!av.sdram_av_byteenable_n[0])
        ram[word_addr][7:0] <= av.sdram_av_writedata[7:0];
      if (!av.sdram_av_byteenable_n[1])
        ram[word_addr][15:8] <= av.sdram_av_writedata[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      pending        <= '0;
      rdv_q          <= 1'b0;
      rdata_q        <= '0;
      ref_cnt        <= '0;
      protocol_error <= 1'b0;
    end else begin
      ref_cnt <= (ref_cnt == RCW'(REFRESH_PERIOD - 1)) ? '0 : ref_cnt + 1'b1;
      if (cmd_clash)
        protocol_error <= 1'b1;
      pending <= pending_nxt;
      // A returning read is still counted in pending_nxt, so tail_vld can
      // only be set on the way into (or while staying in) BUSY.
      case (state)
        IDLE: begin
          rdv_q <= tail_vld;
          if (tail_vld)
            rdata_q <= tail_dat;
          if (pending_nxt != '0)
            state <= BUSY;
        end
        BUSY: begin
          rdv_q <= tail_vld;
          if (tail_vld)
            rdata_q <= tail_dat;
          if (pending_nxt == '0)
            state <= IDLE;
        end
        default: begin
          rdv_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_av_responder.sv
module tb_sdram_av_responder;
  localparam int AB = 10;
  localparam int RL = 3;
  localparam int MP = 2;
  localparam int RP = 64;
  localparam int RC = 4;
  localparam int DEPTH = 1 << AB;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic protocol_error;
  always #5 clk = ~clk;

  sdram_av_responder_if bus();

  sdram_av_responder #(
    .ADDR_BITS(AB), .READ_LATENCY(RL), .MAX_PENDING(MP),
    .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .av(bus.slave),
    .protocol_error(protocol_error)
  );

  // Reference model: memory image, queue of reads with their due cycle.
  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  logic [15:0] mem [DEPTH];
  rd_t         q[$];
  logic [15:0] m_last;
  logic        m_perr;
  int          k;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        obs_rdv, obs_wait, obs_perr;
  logic [15:0] obs_rdata;
  logic        last_acc_rd, last_acc_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  // Called at a falling edge: check this cycle's outputs against the model,
  // present the command, advance the model, move to the next falling edge.
  task automatic step(input logic cs, input logic rd_n, input logic wr_n,
                      input logic [1:0] be_n, input logic [21:0] addr,
                      input logic [15:0] wd);
    logic exp_rdv, exp_wait, acc_rd, acc_wr;
    int a;
    obs_rdv   = bus.sdram_av_readdatavalid;
    obs_rdata = bus.sdram_av_readdata;
    obs_wait  = bus.sdram_av_waitrequest;
    obs_perr  = protocol_error;
    exp_rdv   = (q.size() > 0) && (q[0].due == k);
    if (exp_rdv) m_last = q[0].data;
    exp_wait  = ((k % RP) >= (RP - RC)) || (q.size() == MP);
    chk("readdatavalid", 32'(obs_rdv), 32'(exp_rdv));
    chk("readdata", 32'(obs_rdata), 32'(m_last));
    chk("waitrequest", 32'(obs_wait), 32'(exp_wait));
    chk("protocol_error", 32'(obs_perr), 32'(m_perr));
    if (exp_rdv) void'(q.pop_front());

    bus.sdram_av_chipselect   = cs;
    bus.sdram_av_read_n       = rd_n;
    bus.sdram_av_write_n      = wr_n;
    bus.sdram_av_byteenable_n = be_n;
    bus.sdram_av_address      = addr;
    bus.sdram_av_writedata    = wd;

    a = int'(addr) % DEPTH;
    acc_rd = cs && !rd_n && wr_n && !exp_wait;
    acc_wr = cs && !wr_n && rd_n && !exp_wait;
    if (cs && !rd_n && !wr_n) m_perr = 1'b1;
    if (acc_rd) q.push_back('{k + RL, mem[a]});
    if (acc_wr) begin
      if (!be_n[0]) mem[a][7:0]  = wd[7:0];
      if (!be_n[1]) mem[a][15:8] = wd[15:8];
    end
    last_acc_rd = acc_rd;
    last_acc_wr = acc_wr;
    @(negedge clk);
    k++;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b1, 2'b11, 22'd0, 16'd0);
  endtask

  task automatic do_reset();
    bus.sdram_av_chipselect = 1'b0;
    bus.sdram_av_read_n     = 1'b1;
    bus.sdram_av_write_n    = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    m_last = 16'd0;
    m_perr = 1'b0;
    k = 0;
  endtask

  typedef struct {
    logic        cs, rd_n, wr_n;
    logic [1:0]  be_n;
    logic [21:0] addr;
    logic [15:0] wd;
    logic        e_rdv;
    logic [15:0] e_rdata;
    logic        e_wait;
    logic        e_perr;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int tries, acc_cycle, kk;
    logic [21:0] ra;
    logic [15:0] rd;
    logic cs, rn, wn;
    logic [7:0] wpat;

    //           cs  rd_n wr_n be_n   addr      wd        rdv  rdata     wait perr
    tbl[0]  = '{1'b1,1'b1,1'b0,2'b00,22'h010,16'hA5C3, 1'b0,16'h0000,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b1,2'b00,22'h010,16'h0000, 1'b0,16'h0000,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b1,2'b11,22'h000,16'h0000, 1'b0,16'h0000,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b0,2'b00,22'h020,16'hFFFF, 1'b0,16'h0000,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0,2'b10,22'h020,16'h1234, 1'b1,16'hA5C3,1'b0,1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b1,2'b00,22'h020,16'h0000, 1'b0,16'hA5C3,1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b0,2'b00,22'h000,16'hBEEF, 1'b0,16'hA5C3,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b1,2'b00,22'h400,16'h0000, 1'b0,16'hA5C3,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b1,2'b11,22'h000,16'h0000, 1'b1,16'hFF34,1'b1,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b1,2'b11,22'h000,16'h0000, 1'b0,16'hFF34,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b1,2'b11,22'h000,16'h0000, 1'b1,16'hBEEF,1'b0,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b0,2'b00,22'h010,16'h0000, 1'b0,16'hBEEF,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b1,1'b0,2'b00,22'h010,16'h0000, 1'b0,16'hBEEF,1'b0,1'b1};
    tbl[13] = '{1'b1,1'b0,1'b1,2'b00,22'h010,16'h0000, 1'b0,16'hBEEF,1'b0,1'b1};
    tbl[14] = '{1'b0,1'b0,1'b1,2'b00,22'h010,16'h0000, 1'b0,16'hBEEF,1'b0,1'b1};
    tbl[15] = '{1'b0,1'b1,1'b1,2'b11,22'h000,16'h0000, 1'b0,16'hBEEF,1'b0,1'b1};
    tbl[16] = '{1'b0,1'b1,1'b1,2'b11,22'h000,16'h0000, 1'b1,16'hA5C3,1'b0,1'b1};
    tbl[17] = '{1'b0,1'b1,1'b1,2'b11,22'h000,16'h0000, 1'b0,16'hA5C3,1'b0,1'b1};

    @(negedge clk);
    do_reset();

    // Fill every word so all later reads have a known expected value.
    for (int a = 0; a < DEPTH; a++) begin
      rd = 16'($urandom);
      tries = 0;
      do begin
        step(1'b1, 1'b1, 1'b0, 2'b00, 22'(a), rd);
        tries++;
      end while (!last_acc_wr && tries < 50);
      if (!last_acc_wr) chk("fill_accept", 32'd0, 32'd1);
    end

    // Directed table; RAM contents survive this reset.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].cs, tbl[i].rd_n, tbl[i].wr_n, tbl[i].be_n, tbl[i].addr, tbl[i].wd);
      chk("tbl_rdv", 32'(obs_rdv), 32'(tbl[i].e_rdv));
      chk("tbl_rdata", 32'(obs_rdata), 32'(tbl[i].e_rdata));
      chk("tbl_wait", 32'(obs_wait), 32'(tbl[i].e_wait));
      chk("tbl_perr", 32'(obs_perr), 32'(tbl[i].e_perr));
    end

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 700; n++) begin
      int r;
      r  = int'($urandom_range(0, 99));
      cs = ($urandom_range(0, 9) != 0);
      if (r < 40)      begin rn = 1'b0; wn = 1'b1; end
      else if (r < 80) begin rn = 1'b1; wn = 1'b0; end
      else if (r < 82) begin rn = 1'b0; wn = 1'b0; end
      else             begin rn = 1'b1; wn = 1'b1; end
      ra = 22'($urandom);
      if ($urandom_range(0, 1) == 1) ra = 22'($urandom_range(0, 15)) | (ra & 22'h3FFC00);
      wpat = 8'($urandom);
      step(cs, rn, wn, 2'($urandom), ra, {wpat, 8'($urandom)});
    end

    // Reads held every cycle: stall after MAX_PENDING accepts.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      kk = k;
      step(1'b1, 1'b0, 1'b1, 2'b00, 22'(i * 7), 16'd0);
      if (kk == 1) chk("hold_wait_c1", 32'(obs_wait), 32'd0);
      if (kk == 2) chk("hold_wait_c2", 32'(obs_wait), 32'd1);
      if (kk == 3) chk("hold_rdv_c3", 32'(obs_rdv), 32'd1);
      if (kk == 4) chk("hold_rdv_c4", 32'(obs_rdv), 32'd1);
    end
    for (int i = 0; i < 6; i++) idle();

    // Two reads straddle the refresh window; a held read waits for counter 0.
    do_reset();
    while (k < 57) idle();
    step(1'b1, 1'b0, 1'b1, 2'b00, 22'h055, 16'd0);
    chk("pre_refresh_acc0", 32'(last_acc_rd), 32'd1);
    step(1'b1, 1'b0, 1'b1, 2'b00, 22'h056, 16'd0);
    chk("pre_refresh_acc1", 32'(last_acc_rd), 32'd1);
    acc_cycle = -1;
    tries = 0;
    while (acc_cycle < 0 && tries < 20) begin
      kk = k;
      step(1'b1, 1'b0, 1'b1, 2'b00, 22'h057, 16'd0);
      if (kk >= 60 && kk <= 63) chk("refresh_wait", 32'(obs_wait), 32'd1);
      if (kk == 60 || kk == 61) chk("refresh_rdv", 32'(obs_rdv), 32'd1);
      if (last_acc_rd) acc_cycle = kk;
      tries++;
    end
    chk("held_read_accept_cycle", 32'(acc_cycle), 32'd64);
    while (k < 70) begin
      kk = k;
      idle();
      if (kk == 67) chk("post_refresh_rdv", 32'(obs_rdv), 32'd1);
    end

    // Reset with a read in flight: it never returns, pending restarts at 0.
    do_reset();
    idle();
    step(1'b1, 1'b0, 1'b1, 2'b00, 22'h010, 16'd0);
    chk("inflight_accept", 32'(last_acc_rd), 32'd1);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("no_rdv_after_reset", 32'(obs_rdv), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      kk = k;
      step(1'b1, 1'b0, 1'b1, 2'b00, 22'h011, 16'd0);
      if (kk == 7) chk("post_reset_wait1", 32'(obs_wait), 32'd0);
      if (kk == 8) chk("post_reset_wait2", 32'(obs_wait), 32'd1);
    end
    for (int i = 0; i < 6; i++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
